// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue/sequencing stage.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // Quotient returned for a zero divisor.
  localparam logic [DIV_WIDTH-1:0] DIV_DBZ_Q = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_issue_ctrl_sign_fix.sv
// Combinational two's-complement magnitude/negate helper, one lane per operand.
module div_sign_fix #(
  parameter int WIDTH = 32,
  parameter int LANES = 1
) (
  input  logic [LANES-1:0][WIDTH-1:0] val,
  input  logic [LANES-1:0]            neg,
  output logic [LANES-1:0][WIDTH-1:0] res
);

  always_comb begin
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      res[i] = neg[i] ? ('0 - val[i]) : val[i];
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequencer around the external combinational divider: accept, hold inputs SETTLE_CYCLES, return quotient.
// DIV_SIGNED_EN selects two's-complement operands; default build is unsigned.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH         = DIV_WIDTH,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_dbz
);

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  div_state_t       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] out_q_q, out_q_d;
  logic             out_dbz_q, out_dbz_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] res_fix;

`ifdef DIV_SIGNED_EN
  logic                  sign_q, sign_d;
  logic [1:0][WIDTH-1:0] opnd_mag;

  div_sign_fix #(
    .WIDTH (WIDTH),
    .LANES (2)
  ) u_opnd_fix (
    .val ({in_b, in_a}),
    .neg ({in_b[WIDTH-1], in_a[WIDTH-1]}),
    .res (opnd_mag)
  );

  // Divider sees magnitudes; the latched sign re-applies to its unsigned result.
  div_sign_fix #(
    .WIDTH (WIDTH),
    .LANES (1)
  ) u_res_fix (
    .val (div_res),
    .neg (sign_q),
    .res (res_fix)
  );

  assign mag_a = opnd_mag[0];
  assign mag_b = opnd_mag[1];
`else
  assign mag_a   = in_a;
  assign mag_b   = in_b;
  assign res_fix = div_res;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    out_q_d     = out_q_q;
    out_dbz_d   = out_dbz_q;
    out_valid_d = out_valid_q;
`ifdef DIV_SIGNED_EN
    sign_d      = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_b == '0) begin
            // Zero divisor bypasses the divider entirely; its inputs keep the last operands.
            out_q_d     = {WIDTH{DIV_DBZ_Q[0]}};
            out_dbz_d   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            div_a_d = mag_a;
            div_b_d = mag_b;
            cnt_d   = '0;
`ifdef DIV_SIGNED_EN
            sign_d  = in_a[WIDTH-1] ^ in_b[WIDTH-1];
`endif
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) begin
          out_q_d     = res_fix;
          out_dbz_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      out_q_q     <= '0;
      out_dbz_q   <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      sign_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      out_q_q     <= out_q_d;
      out_dbz_q   <= out_dbz_d;
      out_valid_q <= out_valid_d;
`ifdef DIV_SIGNED_EN
      sign_q      <= sign_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_dbz   = out_dbz_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized bench for div_issue_ctrl with an arithmetic reference model and a behavioural divider.
module tb_div_issue_ctrl;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic [W-1:0] div_res;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_q;
  logic         out_dbz;

  int n_checks = 0;
  int n_errors = 0;

  // Divider inputs as the model expects them to sit after the last nonzero accept.
  logic [W-1:0] mdl_a;
  logic [W-1:0] mdl_b;

  div_issue_ctrl #(
    .WIDTH         (W),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_res   (div_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_dbz   (out_dbz)
  );

  // Unsigned combinational restoring divider stand-in.
  assign div_res = (div_b == '0) ? '1 : div_a / div_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mag(input logic [W-1:0] x);
`ifdef DIV_SIGNED_EN
    longint v;
    v = longint'($signed(x));
    if (v < 0) v = -v;
    return v[W-1:0];
`else
    return x;
`endif
  endfunction

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    longint q;
    if (b == '0) return '1;
`ifdef DIV_SIGNED_EN
    q = longint'($signed(a)) / longint'($signed(b));
`else
    q = longint'({32'd0, a}) / longint'({32'd0, b});
`endif
    return q[W-1:0];
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit toggle);
    logic [W-1:0] eq;
    int k;
    eq = ref_q(a, b);
    if (b != '0) begin
      mdl_a = ref_mag(a);
      mdl_b = ref_mag(b);
    end
    chk("pre_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 300) begin
      chk("settle_div_a", div_a, mdl_a);
      chk("settle_div_b", div_b, mdl_b);
      if (toggle) begin
        in_a = $urandom;
        in_b = $urandom;
      end
      @(negedge clk);
      k++;
    end
    chk("latency", k, (b == '0) ? 1 : S + 1);
    chk("out_q", out_q, eq);
    chk("out_dbz", out_dbz, (b == '0));
    chk("div_a", div_a, mdl_a);
    chk("div_b", div_b, mdl_b);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a     = $urandom;
      in_b     = $urandom;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_q", out_q, eq);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    mdl_a     = '0;
    mdl_b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_dbz", out_dbz, 0);
    chk("rst_div_a", div_a, 0);
    chk("rst_div_b", div_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd100, 32'd7, 0, 1'b0);
    run_op(32'h12345678, 32'd0, 0, 1'b0);
    run_op(32'd1000, 32'd33, 10, 1'b0);
    run_op(32'hFFFFFFFF, 32'd1, 0, 1'b1);
    run_op(32'd5, 32'd9, 2, 1'b1);
`ifdef DIV_SIGNED_EN
    run_op(-32'sd100, 32'd7, 0, 1'b0);
    run_op(32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    run_op(32'd100, -32'sd7, 1, 1'b1);
    run_op(-32'sd99, -32'sd10, 0, 1'b0);
`endif

    // Reset during SETTLE abandons the operation.
    in_valid = 1'b1;
    in_a     = 32'd777;
    in_b     = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_q", out_q, 0);
    chk("mid_rst_out_dbz", out_dbz, 0);
    chk("mid_rst_div_a", div_a, 0);
    chk("mid_rst_div_b", div_b, 0);
    rst_n = 1'b1;
    mdl_a = '0;
    mdl_b = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_in_ready", in_ready, 1);
    end

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 20));
        2:       b = W'($urandom_range(1, 65535));
        default: b = $urandom;
      endcase
      run_op(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
